// File: rtl/depacketizer_stream.sv
// rtl/depacketizer_stream.sv - serialises FLIT_W-bit flits into DATA_W-bit words, MSB word first
// Optional completed-packet counter enabled by defining DEPKT_PKTCNT_EN.
module depacketizer_stream #(
    parameter int FLIT_W = 48,
    parameter int DATA_W = 16,
    parameter int WORDS  = FLIT_W / DATA_W,
    parameter int CW     = $clog2(WORDS + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [FLIT_W-1:0] flit_in,
    input  logic              flit_valid,
    input  logic              flit_last,
    input  logic [CW-1:0]     flit_words,
    output logic              flit_ready,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    input  logic              data_ready,
`ifdef DEPKT_PKTCNT_EN
    output logic [15:0]       pkt_count,
`endif
    output logic              packet_end
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic [0:0]        r_state;
    logic [FLIT_W-1:0] r_shreg;
    logic [CW-1:0]     r_cnt;
    logic              r_last_q;

    logic w_data_valid;
    logic w_last_word;
    logic w_accept;
    logic w_xfer;

    assign w_data_valid = (r_state == ST_SHIFT);
    assign w_last_word  = (r_cnt == CW'(1));
    // A new flit may load in the same cycle the final word of the current one leaves.
    assign flit_ready   = reset && (!w_data_valid || (data_ready && w_last_word));
    assign w_accept     = flit_valid && flit_ready;
    assign w_xfer       = w_data_valid && data_ready;

    assign data_out   = r_shreg[FLIT_W-1 -: DATA_W];
    assign data_valid = w_data_valid;
    assign packet_end = w_data_valid && w_last_word && r_last_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_shreg  <= '0;
            r_cnt    <= '0;
            r_last_q <= 1'b0;
        end else if (w_accept) begin
            r_shreg  <= flit_in;
            r_cnt    <= (flit_last && flit_words != '0) ? flit_words : CW'(WORDS);
            r_last_q <= flit_last;
            r_state  <= ST_SHIFT;
        end else if (w_xfer) begin
            if (!w_last_word) begin
                r_shreg <= r_shreg << DATA_W;
                r_cnt   <= r_cnt - CW'(1);
            end else begin
                r_state <= ST_IDLE;
            end
        end
    end

`ifdef DEPKT_PKTCNT_EN
    logic [15:0] r_pkt_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pkt_count <= '0;
        end else if (packet_end && data_ready) begin
            r_pkt_count <= r_pkt_count + 16'd1;
        end
    end

    assign pkt_count = r_pkt_count;
`endif

endmodule

// File: tb/tb_depacketizer_stream.sv
// tb/tb_depacketizer_stream.sv - directed self-checking bench for depacketizer_stream
module tb_depacketizer_stream;

    localparam int FLIT_W = 48;
    localparam int DATA_W = 16;
    localparam int CW     = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [FLIT_W-1:0] flit_in;
    logic              flit_valid;
    logic              flit_last;
    logic [CW-1:0]     flit_words;
    logic              flit_ready;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              data_ready;
    logic              packet_end;
`ifdef DEPKT_PKTCNT_EN
    logic [15:0]       pkt_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    depacketizer_stream #(.FLIT_W(FLIT_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .flit_in    (flit_in),
        .flit_valid (flit_valid),
        .flit_last  (flit_last),
        .flit_words (flit_words),
        .flit_ready (flit_ready),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
`ifdef DEPKT_PKTCNT_EN
        .pkt_count  (pkt_count),
`endif
        .packet_end (packet_end)
    );

    task automatic test_reset;
        reset      = 1'b0;
        flit_valid = 1'b1;
        flit_in    = 48'hDEAD_BEEF_CAFE;
        flit_last  = 1'b1;
        flit_words = 2'd0;
        data_ready = 1'b1;
        repeat (2) begin
            @(negedge clk); #1;
            n_checks++;
            if (data_valid !== 1'b0 || flit_ready !== 1'b0 || data_out !== 16'h0 || packet_end !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_outputs: got valid=%b ready=%b data=%h pe=%b, required 0 0 0000 0",
                         data_valid, flit_ready, data_out, packet_end);
            end
        end
        @(negedge clk);
        reset      = 1'b1;
        flit_valid = 1'b0;
        #1;
        n_checks++;
        if (flit_ready !== 1'b1 || data_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got ready=%b valid=%b, required 1 0", flit_ready, data_valid);
        end
        @(negedge clk); #1;
        n_checks++;
        if (data_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_capture: got valid=%b, required 0", data_valid);
        end
    endtask

    task automatic test_single_flit;
        logic [15:0] exp_w [3] = '{16'h1234, 16'hABCD, 16'hFFFF};
        @(negedge clk);
        flit_in    = 48'h1234_ABCD_FFFF;
        flit_last  = 1'b1;
        flit_words = 2'd0;
        flit_valid = 1'b1;
        data_ready = 1'b1;
        #1;
        n_checks++;
        if (flit_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL single_accept: got ready=%b, required 1", flit_ready);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            flit_valid = 1'b0;
            #1;
            n_checks++;
            if (data_valid !== 1'b1 || data_out !== exp_w[i] || packet_end !== (i == 2)) begin
                n_fail++;
                $display("FAIL single_word%0d: got valid=%b data=%h pe=%b, required 1 %h %b",
                         i, data_valid, data_out, packet_end, exp_w[i], (i == 2));
            end
        end
        @(negedge clk); #1;
        n_checks++;
        if (data_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_idle: got valid=%b, required 0", data_valid);
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] exp_w  [5] = '{16'h1234, 16'hABCD, 16'hFFFF, 16'h3232, 16'h6767};
        logic        exp_rdy[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        @(negedge clk);
        flit_in    = 48'h1234_ABCD_FFFF;
        flit_last  = 1'b0;
        flit_words = 2'd0;
        flit_valid = 1'b1;
        data_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) begin
                flit_in    = 48'h3232_6767_FFFF;
                flit_last  = 1'b1;
                flit_words = 2'd2;
            end
            if (i == 3) flit_valid = 1'b0;
            #1;
            n_checks++;
            if (data_valid !== 1'b1 || data_out !== exp_w[i] || packet_end !== (i == 4) ||
                flit_ready !== exp_rdy[i]) begin
                n_fail++;
                $display("FAIL b2b_word%0d: got valid=%b data=%h pe=%b ready=%b, required 1 %h %b %b",
                         i, data_valid, data_out, packet_end, flit_ready, exp_w[i], (i == 4), exp_rdy[i]);
            end
        end
        @(negedge clk); #1;
        n_checks++;
        if (data_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_no_trailing: got valid=%b data=%h, required valid 0", data_valid, data_out);
        end
    endtask

    task automatic test_backpressure;
        @(negedge clk);
        flit_in    = 48'h1234_ABCD_FFFF;
        flit_last  = 1'b1;
        flit_words = 2'd0;
        flit_valid = 1'b1;
        data_ready = 1'b1;
        @(negedge clk);
        flit_valid = 1'b0;
        #1;
        n_checks++;
        if (data_out !== 16'h1234 || data_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_first: got data=%h valid=%b, required 1234 1", data_out, data_valid);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            data_ready = 1'b0;
            #1;
            n_checks++;
            if (data_out !== 16'hABCD || data_valid !== 1'b1 || flit_ready !== 1'b0 || packet_end !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold%0d: got data=%h valid=%b ready=%b pe=%b, required ABCD 1 0 0",
                         k, data_out, data_valid, flit_ready, packet_end);
            end
        end
        @(negedge clk);
        data_ready = 1'b1;
        #1;
        n_checks++;
        if (data_out !== 16'hABCD || data_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: got data=%h valid=%b, required ABCD 1", data_out, data_valid);
        end
        @(negedge clk); #1;
        n_checks++;
        if (data_out !== 16'hFFFF || data_valid !== 1'b1 || packet_end !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_resume: got data=%h valid=%b pe=%b, required FFFF 1 1", data_out, data_valid, packet_end);
        end
        @(negedge clk); #1;
        n_checks++;
        if (data_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_idle: got valid=%b, required 0", data_valid);
        end
    endtask

    task automatic test_reset_mid_packet;
        logic [15:0] exp_w [3] = '{16'h3232, 16'h6767, 16'hFFFF};
        @(negedge clk);
        flit_in    = 48'h1234_ABCD_FFFF;
        flit_last  = 1'b1;
        flit_words = 2'd0;
        flit_valid = 1'b1;
        data_ready = 1'b1;
        @(negedge clk);
        flit_valid = 1'b0;
        #1;
        n_checks++;
        if (data_out !== 16'h1234 || data_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rmid_first: got data=%h valid=%b, required 1234 1", data_out, data_valid);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++;
        if (data_valid !== 1'b0 || packet_end !== 1'b0 || flit_ready !== 1'b0 || data_out !== 16'h0) begin
            n_fail++;
            $display("FAIL rmid_reset: got valid=%b pe=%b ready=%b data=%h, required 0 0 0 0000",
                     data_valid, packet_end, flit_ready, data_out);
        end
        @(negedge clk);
        reset      = 1'b1;
        flit_in    = 48'h3232_6767_FFFF;
        flit_last  = 1'b1;
        flit_words = 2'd0;
        flit_valid = 1'b1;
        #1;
        n_checks++;
        if (flit_ready !== 1'b1 || data_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_restart: got ready=%b valid=%b, required 1 0", flit_ready, data_valid);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            flit_valid = 1'b0;
            #1;
            n_checks++;
            if (data_valid !== 1'b1 || data_out !== exp_w[i] || packet_end !== (i == 2)) begin
                n_fail++;
                $display("FAIL rmid_word%0d: got valid=%b data=%h pe=%b, required 1 %h %b",
                         i, data_valid, data_out, packet_end, exp_w[i], (i == 2));
            end
        end
    endtask

    task automatic test_partial_single_word;
        @(negedge clk);
        flit_in    = 48'hAAAA_BBBB_CCCC;
        flit_last  = 1'b1;
        flit_words = 2'd1;
        flit_valid = 1'b1;
        data_ready = 1'b1;
        @(negedge clk);
        flit_in = 48'h5555_6666_7777;
        #1;
        n_checks++;
        if (data_out !== 16'hAAAA || packet_end !== 1'b1 || flit_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL partial_first: got data=%h pe=%b ready=%b, required AAAA 1 1", data_out, packet_end, flit_ready);
        end
        @(negedge clk);
        flit_valid = 1'b0;
        #1;
        n_checks++;
        if (data_out !== 16'h5555 || packet_end !== 1'b1 || data_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL partial_second: got data=%h pe=%b valid=%b, required 5555 1 1", data_out, packet_end, data_valid);
        end
        @(negedge clk); #1;
        n_checks++;
        if (data_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL partial_idle: got valid=%b data=%h, required valid 0", data_valid, data_out);
        end
    endtask

`ifdef DEPKT_PKTCNT_EN
    task automatic test_pkt_count;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_checks++;
        if (pkt_count !== 16'd0) begin
            n_fail++;
            $display("FAIL pktcnt_reset: got %0d, required 0", pkt_count);
        end
        flit_in    = 48'h0001_0002_0003;
        flit_last  = 1'b1;
        flit_words = 2'd1;
        flit_valid = 1'b1;
        data_ready = 1'b1;
        repeat (3) @(negedge clk);
        flit_valid = 1'b0;
        @(negedge clk); #1;
        n_checks++;
        if (pkt_count !== 16'd3) begin
            n_fail++;
            $display("FAIL pktcnt_three: got %0d, required 3", pkt_count);
        end
    endtask
`endif

    initial begin
        reset      = 1'b0;
        flit_in    = '0;
        flit_valid = 1'b0;
        flit_last  = 1'b0;
        flit_words = '0;
        data_ready = 1'b0;
        test_reset();
        test_single_flit();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_packet();
        test_partial_single_word();
`ifdef DEPKT_PKTCNT_EN
        test_pkt_count();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/depacketizer_stream.md
Name: depacketizer_stream

Overview:
- Parametrised successor to the fixed 48-to-16-bit depacketizer.
- Accepts flits of FLIT_W bits over a valid/ready handshake and serialises each flit into FLIT_W/DATA_W words, MSB word first, with a valid/ready handshake.
- Marks the last word of each packet with packet_end.
- Supports partial last flits, backpressure and zero-bubble flit-to-flit streaming.
- Sits between the NoC router ejection port and the PE data sink.

Parameters:
- FLIT_W, 48: flit width in bits. Must be an integer multiple of DATA_W.
- DATA_W, 16: output word width in bits.
- WORDS, FLIT_W/DATA_W: derived words per flit. Must be ≥2.
- CW, $clog2(WORDS+1): derived width of flit_words and the internal word counter.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- flit_in  input  FLIT_W  incoming flit
- flit_valid  input  1  flit_in valid
- flit_last  input  1  flit is the final flit of its packet
- flit_words  input  CW  valid words in a last flit (1..WORDS; 0 means WORDS). Ignored when flit_last=0.
- flit_ready  output  1  block accepts flit this cycle
- data_out  output  DATA_W  current output word
- data_valid  output  1  data_out valid
- data_ready  input  1  downstream accepts word
- packet_end  output  1  current word is the last word of the packet
- pkt_count  output  16  completed-packet counter (only when DEPKT_PKTCNT_EN is defined)

Behaviour:
- Internal state:
  - shreg [FLIT_W-1:0]
  - cnt [CW-1:0]: words remaining in the current flit
  - last_q: current flit is a packet's last flit
  - state: IDLE or SHIFT
- Reset (reset=0, asynchronous):
  - state=IDLE, shreg=0, cnt=0, last_q=0.
  - Outputs: data_out=0, data_valid=0, packet_end=0, flit_ready=0, pkt_count=0.
  - Reset mid-packet discards the partial packet. No packet_end is emitted for it.
- Combinational outputs:
  - data_out = shreg[FLIT_W-1 -: DATA_W]
  - data_valid = (state==SHIFT)
  - packet_end = data_valid && cnt==1 && last_q
  - flit_ready = reset && (!data_valid || (data_ready && cnt==1))
- Flit accept: on flit_valid && flit_ready:
  - shreg <= flit_in
  - cnt <= (flit_last && flit_words!=0) ? flit_words : WORDS
  - last_q <= flit_last
  - state <= SHIFT
- Word transfer: on data_valid && data_ready:
  - If cnt>1: shreg <= shreg << DATA_W (zero fill); cnt <= cnt-1.
  - If cnt==1 and a flit is accepted in the same cycle: load that flit (zero bubble).
  - If cnt==1 and no flit is accepted: state <= IDLE; shreg and cnt unchanged.
- Backpressure: while data_valid && !data_ready, shreg, cnt, data_out and packet_end hold stable, and flit_ready=0.
- Latency: a flit accepted at edge N presents its first word after edge N. One word is delivered per cycle under continuous data_ready.
- Partial flits: words beyond flit_words in a last flit are never presented.
- flit_words > WORDS: unsupported. The verification bench must not drive it; no defined response.
- Packet boundaries: there is no header. A packet is the run of flits up to and including the one with flit_last=1.

Optional Feature:
- Macro: DEPKT_PKTCNT_EN.
- Defined:
  - Adds 16-bit output pkt_count, reset to 0.
  - Increments on every cycle with packet_end && data_ready.
  - Wraps 0xFFFF→0x0000.
- Undefined: pkt_count port and counter logic are absent. All other behaviour is identical.

Test Plan:
- Reset: hold reset=0 for 2 cycles with flit_valid=1 → data_valid=0, flit_ready=0, data_out=0. After release, flit_ready=1 and no flit was captured during reset.
- Single flit, data_ready=1: flit_in=48'h1234_ABCD_FFFF, flit_last=1, flit_words=0 → data_out 1234, ABCD, FFFF on 3 consecutive cycles. packet_end=1 only with FFFF, then data_valid=0.
- Two-flit packet, back to back:
  - First flit 48'h1234_ABCD_FFFF with last=0; second flit 48'h3232_6767_FFFF with last=1, words=2, held valid.
  - Words out: 1234, ABCD, FFFF, 3232, 6767 in 5 consecutive cycles.
  - Second flit is accepted in the FFFF cycle. packet_end only on 6767. Trailing FFFF is never output.
- Backpressure: drop data_ready for 3 cycles while data_out=ABCD → data_out holds ABCD, data_valid=1, flit_ready=0. Stream resumes with FFFF.
- Reset mid-packet: assert reset right after 1234 transfers → data_valid falls immediately, no packet_end. The next flit 48'h3232_6767_FFFF (last=1) outputs 3232, 6767, FFFF normally.
- DEPKT_PKTCNT_EN: send 3 packets → pkt_count=3. Force the counter near wrap by sending 65537 single-flit packets → pkt_count=0x0001.
